// File: rtl/wrr_arb_tree.sv
`default_nettype none
// ============================================================================
// Module   : wrr_arb_tree
// Brief    : Weighted round-robin arbiter. Each requester may hold the output
//            for a burst of up to weight_i[i] consecutive transfers per turn
//            (weight 0 counts as 1). With LockIn set, the pending decision is
//            frozen while the output is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module wrr_arb_tree #(
   parameter int          NumIn       = 8,
   parameter int          DataWidth   = 32,
   parameter type         DataType    = logic [DataWidth-1:0],
   parameter int          WeightWidth = 4,
   parameter bit          LockIn      = 1'b1,
   localparam int         IdxW        = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic [NumIn-1:0][WeightWidth-1:0]   weight_i,
   input  logic [NumIn-1:0]                    req_i,
   output logic [NumIn-1:0]                    gnt_o,
   input  DataType [NumIn-1:0]                 data_i,
   output logic                                req_o,
   input  logic                                gnt_i,
   output DataType                             data_o,
   output logic [IdxW-1:0]                     idx_o
);

   if (NumIn == 1) begin : g_single
      // A single requester is passed straight through; no state is needed.
      logic unused_single;
      assign unused_single = ^{clk_i, rst_ni, flush_i, weight_i};

      assign req_o    = req_i[0];
      assign gnt_o[0] = gnt_i;
      assign data_o   = data_i[0];
      assign idx_o    = '0;
   end else begin : g_multi
      // Arbiter state: round-robin start point, burst owner, remaining
      // credit of the current burst, and the stall lock.
      logic [IdxW-1:0]        ptr_q, ptr_d;
      logic [IdxW-1:0]        owner_q, owner_d;
      logic [WeightWidth-1:0] credit_q, credit_d;
      logic                   lock_q, lock_d;

      logic                   owner_req;
      logic                   hold;
      logic                   found;
      logic [IdxW-1:0]        rr_sel;
      logic [IdxW-1:0]        sel;
      logic [IdxW-1:0]        sel_next;
      logic [IdxW-1:0]        owner_next;
      logic [WeightWidth-1:0] eff_w;
      logic [WeightWidth-1:0] base;
      logic [WeightWidth-1:0] rem;
      logic                   handshake;

      // The owner keeps the output while locked or while its burst has
      // credit left and it is still requesting.
      assign owner_req = req_i[owner_q];
      assign hold      = lock_q | ((credit_q != '0) & owner_req);

      // Round-robin scan starting at ptr_q; wraps at NumIn, not at 2**IdxW.
      always_comb begin
         found  = 1'b0;
         rr_sel = ptr_q;
         for (int k = 0; k < NumIn; k++) begin
            if (!found && req_i[(int'(ptr_q) + k) % NumIn]) begin
               found  = 1'b1;
               rr_sel = IdxW'((int'(ptr_q) + k) % NumIn);
            end
         end
      end

      assign sel        = hold ? owner_q : rr_sel;
      assign sel_next   = (sel == IdxW'(NumIn - 1)) ? '0 : sel + 1'b1;
      assign owner_next = (owner_q == IdxW'(NumIn - 1)) ? '0 : owner_q + 1'b1;

      // Output mux is purely combinational: zero added latency.
      assign req_o     = req_i[sel];
      assign data_o    = data_i[sel];
      assign idx_o     = sel;
      assign handshake = req_o & gnt_i;

      // Burst length is taken from weight_i only when a new burst starts;
      // an ongoing burst keeps counting down its latched credit.
      assign eff_w = (weight_i[sel] == '0) ? WeightWidth'(1) : weight_i[sel];
      assign base  = hold ? credit_q : eff_w;
      assign rem   = base - WeightWidth'(1);

      // Only the selected requester can be granted, and only on a handshake.
      always_comb begin
         gnt_o      = '0;
         gnt_o[sel] = handshake;
      end

      // Next-state: flush beats handshake, handshake beats lock and abandon.
      always_comb begin
         ptr_d    = ptr_q;
         owner_d  = owner_q;
         credit_d = credit_q;
         lock_d   = lock_q;
         if (flush_i) begin
            ptr_d    = '0;
            owner_d  = '0;
            credit_d = '0;
            lock_d   = 1'b0;
         end else if (handshake) begin
            lock_d = 1'b0;
            if (rem == '0) begin
               credit_d = '0;
               ptr_d    = sel_next;
            end else begin
               owner_d  = sel;
               credit_d = rem;
            end
         end else if (LockIn && req_o && !gnt_i) begin
            // Stalled: freeze the decision until it is accepted.
            lock_d   = 1'b1;
            owner_d  = sel;
            credit_d = base;
         end else if ((credit_q != '0) && !lock_q && !owner_req) begin
            // Owner walked away mid-burst: give up the rest of its turn.
            credit_d = '0;
            ptr_d    = owner_next;
         end
      end

      // State register with asynchronous active-low reset.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ptr_q    <= '0;
            owner_q  <= '0;
            credit_q <= '0;
            lock_q   <= 1'b0;
         end else begin
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            lock_q   <= lock_d;
         end
      end
   end

endmodule
`default_nettype wire
